// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the IF stage (master) and Instruction_memory (slave).
interface fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;

    modport master (output imem_addr, input imem_instr);
    modport slave  (input imem_addr, output imem_instr);
endinterface

// File: rtl/fetch_stage.sv
// IF stage: PC register, IF/ID pipeline register, stall/redirect/flush and end-of-program halt.
// Optional performance counters are compiled in with FETCH_PERF_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 30,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    input  logic                 jump_en,
    input  logic [25:0]          jump_index,
    fetch_stage_if.master        imem,
    output logic [31:0]          if_id_instr,
    output logic [31:0]          if_id_pc_plus4,
    output logic                 if_id_valid,
    output logic                 halted,
    output logic                 misaligned
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_stalls,
    output logic [31:0]          perf_flushes
`endif
);

    localparam logic [31:0] END_ADDR = 32'(MEM_WORDS * 4);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        mis_q, mis_d;

    logic [31:0] pc_plus4;
    logic [31:0] btgt;
    logic [31:0] jtgt;

    assign pc_plus4 = pc_q + 32'd4;
    assign btgt     = {branch_target[31:2], 2'b00};
    assign jtgt     = {pc4_q[31:28], jump_index, 2'b00};

    assign imem.imem_addr = pc_q;
    assign halted         = (pc_q >= END_ADDR);
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc4_q;
    assign if_id_valid    = valid_q;
    assign misaligned     = mis_q;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        mis_d   = mis_q;
        if (branch_taken) begin
            pc_d    = btgt;
            instr_d = NOP_WORD;
            pc4_d   = '0;
            valid_d = 1'b0;
            mis_d   = mis_q | (|branch_target[1:0]);
        end else if (jump_en) begin
            pc_d    = jtgt;
            instr_d = NOP_WORD;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (stall) begin
            pc_d    = pc_q;
        end else if (halted) begin
            // PC parks past the program; bubbles keep flowing without touching memory
            instr_d = NOP_WORD;
            pc4_d   = pc_plus4;
            valid_d = 1'b0;
        end else begin
            pc_d    = pc_plus4;
            instr_d = imem.imem_instr;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] stalls_q, stalls_d;
    logic [31:0] flushes_q, flushes_d;
    logic        redirect;

    assign redirect = branch_taken | jump_en;

    always_comb begin
        fetched_d = fetched_q;
        stalls_d  = stalls_q;
        flushes_d = flushes_q;
        if (redirect) begin
            if (flushes_q != '1) flushes_d = flushes_q + 32'd1;
        end else if (stall) begin
            if (stalls_q != '1) stalls_d = stalls_q + 32'd1;
        end else if (!halted) begin
            if (fetched_q != '1) fetched_d = fetched_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetched_q <= '0;
            stalls_q  <= '0;
            flushes_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            stalls_q  <= stalls_d;
            flushes_q <= flushes_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stalls  = stalls_q;
    assign perf_flushes = flushes_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed steps push expected IF state, a monitor pops and compares.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_en;
    logic [25:0] jump_index;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        halted;
    logic        misaligned;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;
    logic [31:0] perf_flushes;
`endif

    fetch_stage_if ifc ();

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .MEM_WORDS (30),
        .NOP_WORD  (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump_en        (jump_en),
        .jump_index     (jump_index),
        .imem           (ifc.master),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .misaligned     (misaligned)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stalls    (perf_stalls),
        .perf_flushes   (perf_flushes)
`endif
    );

    // Instruction memory model: 30 distinct non-NOP words, garbage beyond the end
    logic [31:0] mem [30];
    logic [31:0] imem_rd;

    initial begin
        for (int i = 0; i < 30; i++) mem[i] = 32'h2400_0001 + (32'(i) << 8);
    end

    always_comb begin
        imem_rd = 32'hDEAD_BEEF;
        if (ifc.imem_addr < 32'd120) imem_rd = mem[ifc.imem_addr[6:2]];
    end
    assign ifc.imem_instr = imem_rd;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        halt;
        logic        mis;
        logic        is_rst;
    } exp_t;

    exp_t sb[$];
    event mon_ev;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Monitor: compares after each rising edge, or on demand for mid-cycle checks
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or mon_ev);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("imem_addr",      ifc.imem_addr,  e.pc);
                chk("if_id_instr",    if_id_instr,    e.instr);
                chk("if_id_pc_plus4", if_id_pc_plus4, e.pc4);
                chk("if_id_valid",    32'(if_id_valid), 32'(e.valid));
                chk("halted",         32'(halted),      32'(e.halt));
                chk("misaligned",     32'(misaligned),  32'(e.mis));
`ifdef FETCH_PERF_EN
                if (e.is_rst) begin
                    chk("perf_fetched", perf_fetched, 32'd0);
                    chk("perf_stalls",  perf_stalls,  32'd0);
                    chk("perf_flushes", perf_flushes, 32'd0);
                end
`endif
            end
        end
    end

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] pc4,
                        input logic v, input logic h, input logic m, input logic r);
        exp_t e;
        e.pc = pc; e.instr = instr; e.pc4 = pc4;
        e.valid = v; e.halt = h; e.mis = m; e.is_rst = r;
        sb.push_back(e);
    endtask

    // One clock: drive inputs on the falling edge, expect state after the next rising edge
    task automatic step(input logic br, input logic [31:0] bt, input logic j, input logic [25:0] ji,
                        input logic st,
                        input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] pc4,
                        input logic v, input logic h, input logic m);
        @(negedge clk);
        reset         = 1'b0;
        branch_taken  = br;
        branch_target = bt;
        jump_en       = j;
        jump_index    = ji;
        stall         = st;
        push(pc, instr, pc4, v, h, m, 1'b0);
    endtask

    initial begin
        int wait_cyc;
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump_en = 1'b0; jump_index = '0;
        #2;
        push(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        -> mon_ev;

        // free run
        step(0, 0, 0, 0, 0, 32'h04, mem[0], 32'h04, 1, 0, 0);
        step(0, 0, 0, 0, 0, 32'h08, mem[1], 32'h08, 1, 0, 0);
        // stall twice at pc=8, then resume
        step(0, 0, 0, 0, 1, 32'h08, mem[1], 32'h08, 1, 0, 0);
        step(0, 0, 0, 0, 1, 32'h08, mem[1], 32'h08, 1, 0, 0);
        step(0, 0, 0, 0, 0, 32'h0C, mem[2], 32'h0C, 1, 0, 0);
        // branch overrides stall
        step(1, 32'h48, 0, 0, 1, 32'h48, 32'h0, 32'h0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 32'h4C, mem[18], 32'h4C, 1, 0, 0);
        // jump past end of program
        step(0, 0, 1, 26'h1F, 0, 32'h7C, 32'h0, 32'h0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 32'h7C, 32'h0, 32'h80, 0, 1, 0);
        step(0, 0, 0, 0, 0, 32'h7C, 32'h0, 32'h80, 0, 1, 0);
        // last word, then exactly END_ADDR
        step(1, 32'h74, 0, 0, 0, 32'h74, 32'h0, 32'h0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 32'h78, mem[29], 32'h78, 1, 1, 0);
        step(0, 0, 0, 0, 0, 32'h78, 32'h0, 32'h7C, 0, 1, 0);
        // branch and jump together, misaligned target
        step(1, 32'h3A, 1, 26'h1F, 0, 32'h38, 32'h0, 32'h0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 32'h3C, mem[14], 32'h3C, 1, 0, 1);
        step(0, 0, 1, 26'h7, 0, 32'h1C, 32'h0, 32'h0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 32'h20, mem[7], 32'h20, 1, 0, 1);
        step(0, 0, 0, 0, 1, 32'h20, mem[7], 32'h20, 1, 0, 1);

        // asynchronous reset in the middle of a stall cycle
        @(negedge clk);
        #2;
        reset = 1'b1;
        push(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        -> mon_ev;

        // redirect to the top of the address space; halted pc+4 wraps
        step(1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 1, 0);

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (sb.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
